// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//   Sequences one RV32I load/store per instruction from the EX stage onto a
//   req/ack data memory port. Handles byte/halfword lane steering for stores,
//   lane extraction and sign/zero extension for loads, and holds the pipeline
//   until the access completes. Misaligned, illegal-size and timed-out
//   accesses are flagged on fault_o/fault_cause_o.
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; accepts, faults or ignores it
//   BUSY  | dmem_req_o held high until ack or timeout
//   DONE  | one-cycle completion: rdata_o stable, pipeline released
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               discard the current instruction's result
//   req_valid_i/we/funct3/addr/wdata   load/store command from EX
//   stall_o               pipeline hold
//   rdata_o, rdata_valid_o             extended load data, completion pulse
//   fault_o, fault_cause_o             fault pulse; cause 01 misaligned,
//                                      10 illegal size, 11 timeout (held)
//   dmem_req_o/we/addr/be/wdata        memory request side
//   dmem_ack_i, dmem_rdata_i           memory completion and read word
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYC);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_cause;
  logic [7:0]  r_cnt;
  logic        r_flushed;
  logic        r_to_flag;

  logic        w_size_illegal;
  logic        w_misaligned;
  logic        w_req_live;
  logic        w_accept;
  logic        w_fault_req;
  logic [1:0]  w_fault_cause;
  logic [3:0]  w_be_base;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;
  logic [31:0] w_load_ext;
  logic [7:0]  w_cnt_inc;
  logic        w_ack;
  logic        w_timeout;
  logic        w_flush_seen;
  logic        w_end_busy;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_size_illegal = 1'b0;
    case (req_funct3_i)
      3'b011, 3'b110, 3'b111: w_size_illegal = 1'b1;
      3'b100, 3'b101:         w_size_illegal = req_we_i;  // no unsigned stores
      default:                w_size_illegal = 1'b0;
    endcase
  end

  assign w_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));

  // Reset is folded in so the combinational IDLE outputs read 0 during reset.
  assign w_req_live    = !rst_i && (r_state == S_IDLE) && req_valid_i && !flush_i;
  assign w_accept      = w_req_live && !w_size_illegal && !w_misaligned;
  assign w_fault_req   = w_req_live && (w_size_illegal || w_misaligned);
  assign w_fault_cause = w_size_illegal ? 2'b10 : 2'b01;

  always_comb begin
    w_be_base = 4'b1111;
    w_wdata   = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        w_be_base = 4'b0001;
        w_wdata   = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be_base = 4'b0011;
        w_wdata   = {2{req_wdata_i[15:0]}};
      end
      default: begin
        w_be_base = 4'b1111;
        w_wdata   = req_wdata_i;
      end
    endcase
  end

  assign w_be = w_be_base << req_addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Load extraction from the latched command
  // ---------------------------------------------------------------------------
  assign w_rshift = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = w_rshift;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b100:  w_load_ext = {24'h0, w_rshift[7:0]};
      3'b001:  w_load_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b101:  w_load_ext = {16'h0, w_rshift[15:0]};
      default: w_load_ext = w_rshift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Busy-phase control
  // ---------------------------------------------------------------------------
  assign w_cnt_inc    = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  assign w_ack        = (r_state == S_BUSY) && dmem_ack_i;
  assign w_timeout    = (r_state == S_BUSY) && !dmem_ack_i && (w_cnt_inc == TO_CNT);
  assign w_end_busy   = w_ack || w_timeout;
  // A flush seen in any BUSY cycle, including the one that ends it.
  assign w_flush_seen = r_flushed || flush_i;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    stall_o       = 1'b0;
    dmem_req_o    = 1'b0;
    rdata_valid_o = 1'b0;
    fault_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_accept;
        fault_o = w_fault_req;
        if (w_accept) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
        if (w_end_busy) w_state_next = w_flush_seen ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        rdata_valid_o = !flush_i;
        fault_o       = r_to_flag;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, counter, result and cause registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= 2'b00;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cause   <= 2'b00;
      r_cnt     <= '0;
      r_flushed <= 1'b0;
      r_to_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we_i;
        r_funct3 <= req_funct3_i;
        r_off    <= req_addr_i[1:0];
        r_addr   <= {req_addr_i[31:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_wdata;
      end

      if (r_state == S_BUSY) begin
        r_cnt     <= w_cnt_inc;
        r_flushed <= w_flush_seen;
      end else begin
        r_cnt     <= '0;
        r_flushed <= 1'b0;
      end

      // Timeout fault is only reported for an unflushed access, in DONE.
      r_to_flag <= w_timeout && !w_flush_seen;

      if (w_ack)          r_rdata <= r_we ? 32'h0 : w_load_ext;
      else if (w_timeout) r_rdata <= 32'h0;

      if (w_fault_req)                     r_cause <= w_fault_cause;
      else if (w_timeout && !w_flush_seen) r_cause <= 2'b11;
    end
  end

  assign rdata_o       = r_rdata;
  // Request-cycle faults show their cause in the same cycle as fault_o.
  assign fault_cause_o = w_fault_req ? w_fault_cause : r_cause;
  assign dmem_we_o     = r_we && (r_state == S_BUSY);
  assign dmem_addr_o   = r_addr;
  assign dmem_be_o     = r_be;
  assign dmem_wdata_o  = r_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        fault_o;
  logic [1:0]  fault_cause_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;

  always #5 clk_i = ~clk_i;

  dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_we_i      (req_we_i),
    .req_funct3_i  (req_funct3_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_ack_i    (dmem_ack_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  typedef struct {
    logic        valid;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion or fault pulse pops one expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && (rdata_valid_o === 1'b1 || fault_o === 1'b1)) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed valid=%b fault=%b expected no output",
               rdata_valid_o, fault_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk1("sb_valid", rdata_valid_o, mon_e.valid);
        chk1("sb_fault", fault_o, mon_e.fault);
        if (mon_e.valid) chk("sb_rdata", rdata_o, mon_e.rdata);
        if (mon_e.fault) chk("sb_cause", 32'(fault_cause_o), 32'(mon_e.cause));
      end
    end
  end

  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask

  // One legal access. ack_at = BUSY cycle carrying the ack (0 = never, timeout).
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mem, input int ack_at, input int flush_at,
                        input logic flush_done, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int   busy_n;
    int   stall_n;
    int   req_n;
    logic timed_out;
    exp_t e;
    busy_n    = (ack_at > 0) ? ack_at : TO;
    timed_out = (ack_at == 0);
    if (flush_at == 0 && !flush_done) begin
      e.valid = 1'b1;
      e.fault = timed_out;
      e.cause = timed_out ? 2'b11 : 2'b00;
      e.rdata = timed_out ? 32'h0 : exp_rdata;
      sb.push_back(e);
    end
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    stall_n = 0;
    req_n   = 0;
    @(negedge clk_i);
    chk1({tag, "_accept_stall"}, stall_o, 1'b1);
    chk1({tag, "_accept_noreq"}, dmem_req_o, 1'b0);
    stall_n += int'(stall_o);
    for (int k = 1; k <= busy_n; k++) begin
      nxt();
      dmem_ack_i   = (k == ack_at);
      dmem_rdata_i = (k == ack_at) ? mem : 32'hA5A5_5A5A;
      flush_i      = (k == flush_at);
      if (k == flush_at) req_valid_i = 1'b0;
      @(negedge clk_i);
      stall_n += int'(stall_o);
      req_n   += int'(dmem_req_o);
      chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
      chk({tag, "_be"}, 32'(dmem_be_o), 32'(exp_be));
      chk({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
      chk1({tag, "_we"}, dmem_we_o, we);
    end
    nxt();
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    flush_i      = flush_done;
    @(negedge clk_i);
    chk1({tag, "_after_stall"}, stall_o, 1'b0);
    chk1({tag, "_after_req"}, dmem_req_o, 1'b0);
    if (flush_at != 0 || flush_done) chk1({tag, "_no_valid"}, rdata_valid_o, 1'b0);
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(busy_n + 1));
    chk({tag, "_req_cycles"}, 32'(req_n), 32'(busy_n));
    nxt();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic fault_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_cause);
    exp_t e;
    e.valid = 1'b0;
    e.fault = 1'b1;
    e.cause = exp_cause;
    e.rdata = 32'h0;
    sb.push_back(e);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = 32'h1357_9BDF;
    @(negedge clk_i);
    chk1({tag, "_fault"}, fault_o, 1'b1);
    chk({tag, "_cause"}, 32'(fault_cause_o), 32'(exp_cause));
    chk1({tag, "_stall"}, stall_o, 1'b0);
    chk1({tag, "_req"}, dmem_req_o, 1'b0);
    nxt();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk1({tag, "_req_next"}, dmem_req_o, 1'b0);
    chk1({tag, "_fault_gone"}, fault_o, 1'b0);
    chk({tag, "_cause_held"}, 32'(fault_cause_o), 32'(exp_cause));
    nxt();
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_req", dmem_req_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_cause", 32'(fault_cause_o), 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", 32'(dmem_be_o), 32'h0);
    nxt();
    rst_i = 1'b0;
    nxt();

    //      tag    we    f3      addr          wdata         mem           ack fl fd   be       wdata         rdata
    access("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
    access("lhu",  1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h8001_0000, 1, 0, 1'b0, 4'b1100, 32'h0,        32'h0000_8001);
    access("lh",   1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_0000, 3, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
    access("sb",   1'b1, 3'b000, 32'h0000_0301, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    access("sh",   1'b1, 3'b001, 32'h0000_0302, 32'h1234_56AB, 32'hFFFF_FFFF, 2, 0, 1'b0, 4'b1100, 32'h56AB_56AB, 32'h0);
    access("sw",   1'b1, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,        1, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    access("lw",   1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 2, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    access("lbu",  1'b0, 3'b100, 32'h0000_0501, 32'h0,        32'h0000_9A00, 1, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_009A);
    access("tmo",  1'b0, 3'b010, 32'h0000_0700, 32'h0,        32'h0,        0, 0, 1'b0, 4'b1111, 32'h0,        32'h0);
    @(negedge clk_i);
    chk("tmo_cause_held", 32'(fault_cause_o), 32'h3);
    chk("tmo_rdata_zero", rdata_o, 32'h0);
    nxt();

    fault_req("mis_lw", 1'b0, 3'b010, 32'h0000_0105, 2'b01);
    fault_req("mis_lh", 1'b0, 3'b001, 32'h0000_0201, 2'b01);
    fault_req("ill_sbu", 1'b1, 3'b100, 32'h0000_0100, 2'b10);
    fault_req("ill_011", 1'b0, 3'b011, 32'h0000_0100, 2'b10);
    fault_req("ill_prio", 1'b1, 3'b101, 32'h0000_0201, 2'b10);

    // Flush in IDLE: request ignored, no fault.
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h0000_0900;
    flush_i      = 1'b1;
    @(negedge clk_i);
    chk1("iflush_stall", stall_o, 1'b0);
    chk1("iflush_fault", fault_o, 1'b0);
    nxt();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk_i);
    chk1("iflush_noreq", dmem_req_o, 1'b0);
    nxt();

    access("bflush", 1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h1111_2222, 3, 1, 1'b0, 4'b1111, 32'h0, 32'h0);
    access("dflush", 1'b0, 3'b010, 32'h0000_0804, 32'h0, 32'h3333_4444, 1, 0, 1'b1, 4'b1111, 32'h0, 32'h0);
    access("b2b",    1'b0, 3'b000, 32'h0000_0A02, 32'h0, 32'h0055_0000, 1, 0, 1'b0, 4'b0100, 32'h0, 32'h0000_0055);

    // Reset while BUSY: everything drops without a clock edge.
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h0000_0B00;
    req_wdata_i  = 32'h89AB_CDEF;
    nxt();
    @(negedge clk_i);
    chk1("rbusy_req_pre", dmem_req_o, 1'b1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk1("rbusy_req", dmem_req_o, 1'b0);
    chk1("rbusy_stall", stall_o, 1'b0);
    chk1("rbusy_we", dmem_we_o, 1'b0);
    chk("rbusy_be", 32'(dmem_be_o), 32'h0);
    chk("rbusy_addr", dmem_addr_o, 32'h0);
    chk("rbusy_wdata", dmem_wdata_o, 32'h0);
    chk("rbusy_rdata", rdata_o, 32'h0);
    chk("rbusy_cause", 32'(fault_cause_o), 32'h0);
    nxt();
    req_valid_i = 1'b0;
    nxt();
    rst_i = 1'b0;
    nxt();
    @(negedge clk_i);
    chk1("post_rst_req", dmem_req_o, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
